// File: rtl/issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : issue_sched
// Brief    : RS issue scheduler, per-class round-robin select (ALU/MULT/DIV/BR)
// Revision : 1.0 - initial release
// ============================================================================
module issue_sched #(
    parameter int RS_SZ   = 16,
    parameter int NUM_ALU = 2,
    parameter int DIV_LAT = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [RS_SZ-1:0]                 rs_valid,
    input  logic [RS_SZ-1:0]                 rs_ready,
    input  logic [2*RS_SZ-1:0]               rs_fu_type,
    input  logic                             squash,
    input  logic                             mult_stall,
    output logic [RS_SZ-1:0]                 rs_data_issuing,
    output logic [NUM_ALU-1:0]               alu_issue_valid,
    output logic [NUM_ALU*$clog2(RS_SZ)-1:0] alu_issue_idx,
    output logic                             mult_issue_valid,
    output logic [$clog2(RS_SZ)-1:0]         mult_issue_idx,
    output logic                             div_issue_valid,
    output logic [$clog2(RS_SZ)-1:0]         div_issue_idx,
    output logic                             br_issue_valid,
    output logic [$clog2(RS_SZ)-1:0]         br_issue_idx,
    output logic                             div_busy
);

    localparam int         c_IDX_W   = $clog2(RS_SZ);
    localparam int         c_CNT_W   = $clog2(DIV_LAT);
    localparam logic [1:0] c_FU_ALU  = 2'd0;
    localparam logic [1:0] c_FU_MULT = 2'd1;
    localparam logic [1:0] c_FU_DIV  = 2'd2;
    localparam logic [1:0] c_FU_BR   = 2'd3;

    logic [c_IDX_W-1:0] r_alu_ptr, r_mult_ptr, r_div_ptr, r_br_ptr;
    logic [c_CNT_W-1:0] r_div_cnt;

    logic [RS_SZ-1:0]   w_elig;
    logic [RS_SZ-1:0]   w_alu_elig, w_mult_elig, w_div_elig, w_br_elig;
    logic [RS_SZ-1:0]   w_alu_grant;
    logic [c_IDX_W-1:0] w_alu_last;
    logic [c_IDX_W:0]   w_mult_pick, w_div_pick, w_br_pick;

    // First eligible entry at or after ptr (wrapping); MSB flags a hit.
    function automatic logic [c_IDX_W:0] f_rr_pick(input logic [RS_SZ-1:0]   elig,
                                                   input logic [c_IDX_W-1:0] ptr);
        logic [c_IDX_W:0] pick;
        int               pos;
        pick = '0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            pos = (int'(ptr) + i) % RS_SZ;
            if (elig[pos]) pick = {1'b1, c_IDX_W'(pos)};
        end
        return pick;
    endfunction

    function automatic logic [c_IDX_W-1:0] f_inc(input logic [c_IDX_W-1:0] idx);
        return (int'(idx) == RS_SZ - 1) ? '0 : idx + 1'b1;
    endfunction

    // Holding reset in the eligibility term keeps every grant low during reset.
    assign w_elig = rs_valid & rs_ready & {RS_SZ{~squash & reset}};

    generate
        for (genvar g = 0; g < RS_SZ; g++) begin : g_class
            assign w_alu_elig[g]  = w_elig[g] && (rs_fu_type[2*g +: 2] == c_FU_ALU);
            assign w_mult_elig[g] = w_elig[g] && (rs_fu_type[2*g +: 2] == c_FU_MULT) && !mult_stall;
            assign w_div_elig[g]  = w_elig[g] && (rs_fu_type[2*g +: 2] == c_FU_DIV) && (r_div_cnt == '0);
            assign w_br_elig[g]   = w_elig[g] && (rs_fu_type[2*g +: 2] == c_FU_BR);
        end
    endgenerate

    always_comb begin : p_alu_select
        int n_granted;
        int pos;
        alu_issue_valid = '0;
        alu_issue_idx   = '0;
        w_alu_grant     = '0;
        w_alu_last      = r_alu_ptr;
        n_granted       = 0;
        pos             = 0;
        for (int i = 0; i < RS_SZ; i++) begin
            pos = (int'(r_alu_ptr) + i) % RS_SZ;
            if (w_alu_elig[pos] && (n_granted < NUM_ALU)) begin
                alu_issue_valid[n_granted]                    = 1'b1;
                alu_issue_idx[n_granted*c_IDX_W +: c_IDX_W]   = c_IDX_W'(pos);
                w_alu_grant[pos]                              = 1'b1;
                w_alu_last                                    = c_IDX_W'(pos);
                n_granted++;
            end
        end
    end

    assign w_mult_pick      = f_rr_pick(w_mult_elig, r_mult_ptr);
    assign w_div_pick       = f_rr_pick(w_div_elig, r_div_ptr);
    assign w_br_pick        = f_rr_pick(w_br_elig, r_br_ptr);

    assign mult_issue_valid = w_mult_pick[c_IDX_W];
    assign mult_issue_idx   = w_mult_pick[c_IDX_W-1:0];
    assign div_issue_valid  = w_div_pick[c_IDX_W];
    assign div_issue_idx    = w_div_pick[c_IDX_W-1:0];
    assign br_issue_valid   = w_br_pick[c_IDX_W];
    assign br_issue_idx     = w_br_pick[c_IDX_W-1:0];
    assign div_busy         = (r_div_cnt != '0);

    always_comb begin
        rs_data_issuing = w_alu_grant;
        if (mult_issue_valid) rs_data_issuing[mult_issue_idx] = 1'b1;
        if (div_issue_valid)  rs_data_issuing[div_issue_idx]  = 1'b1;
        if (br_issue_valid)   rs_data_issuing[br_issue_idx]   = 1'b1;
    end

    // Squash zeroes every grant, so pointers hold without an explicit check.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_alu_ptr  <= '0;
            r_mult_ptr <= '0;
            r_div_ptr  <= '0;
            r_br_ptr   <= '0;
            r_div_cnt  <= '0;
        end else begin
            if (|alu_issue_valid) r_alu_ptr  <= f_inc(w_alu_last);
            if (mult_issue_valid) r_mult_ptr <= f_inc(mult_issue_idx);
            if (div_issue_valid)  r_div_ptr  <= f_inc(div_issue_idx);
            if (br_issue_valid)   r_br_ptr   <= f_inc(br_issue_idx);

            if (div_issue_valid)
                r_div_cnt <= c_CNT_W'(DIV_LAT - 1);
            else if (r_div_cnt != '0)
                r_div_cnt <= r_div_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_issue_sched
// Brief    : directed + random bench for issue_sched against a queue-based model
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_sched;

    localparam int RS_SZ   = 16;
    localparam int NUM_ALU = 2;
    localparam int DIV_LAT = 8;
    localparam int IW      = 4;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [RS_SZ-1:0]      rs_valid;
    logic [RS_SZ-1:0]      rs_ready;
    logic [2*RS_SZ-1:0]    rs_fu_type;
    logic                  squash;
    logic                  mult_stall;
    logic [RS_SZ-1:0]      rs_data_issuing;
    logic [NUM_ALU-1:0]    alu_issue_valid;
    logic [NUM_ALU*IW-1:0] alu_issue_idx;
    logic                  mult_issue_valid, div_issue_valid, br_issue_valid;
    logic [IW-1:0]         mult_issue_idx, div_issue_idx, br_issue_idx;
    logic                  div_busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    issue_sched #(.RS_SZ(RS_SZ), .NUM_ALU(NUM_ALU), .DIV_LAT(DIV_LAT)) dut (
        .clock           (clock),
        .reset           (reset),
        .rs_valid        (rs_valid),
        .rs_ready        (rs_ready),
        .rs_fu_type      (rs_fu_type),
        .squash          (squash),
        .mult_stall      (mult_stall),
        .rs_data_issuing (rs_data_issuing),
        .alu_issue_valid (alu_issue_valid),
        .alu_issue_idx   (alu_issue_idx),
        .mult_issue_valid(mult_issue_valid),
        .mult_issue_idx  (mult_issue_idx),
        .div_issue_valid (div_issue_valid),
        .div_issue_idx   (div_issue_idx),
        .br_issue_valid  (br_issue_valid),
        .br_issue_idx    (br_issue_idx),
        .div_busy        (div_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        rs_valid   = '0;
        rs_ready   = '0;
        rs_fu_type = '0;
        squash     = 1'b0;
        mult_stall = 1'b0;
    endtask

    task automatic set_ent(input int j, input logic [1:0] t);
        rs_valid[j]         = 1'b1;
        rs_ready[j]         = 1'b1;
        rs_fu_type[2*j +: 2] = t;
    endtask

    // ---------------- behavioural model: rotating scan lists per class ----------
    int         m_ptr[4];
    longint     m_cyc;
    longint     m_div_free;
    int         mq[$];
    int         m_lim, m_j;
    logic       m_busy;
    logic [15:0] e_iss;
    logic [1:0] e_av;
    int         e_aidx[2];
    logic       e_mv, e_dv, e_bv;
    int         e_midx, e_didx, e_bidx;

    initial begin
        m_cyc      = 0;
        m_div_free = 0;
        foreach (m_ptr[c]) m_ptr[c] = 0;
    end

    always @(negedge clock) begin
        m_cyc++;
        e_iss = '0; e_av = '0; e_mv = 1'b0; e_dv = 1'b0; e_bv = 1'b0;
        e_aidx[0] = 0; e_aidx[1] = 0; e_midx = 0; e_didx = 0; e_bidx = 0;
        m_busy = 1'b0;
        if (!reset) begin
            foreach (m_ptr[c]) m_ptr[c] = 0;
            m_div_free = 0;
        end else begin
            m_busy = (m_cyc < m_div_free);
            for (int c = 0; c < 4; c++) begin
                mq.delete();
                for (int i = 0; i < RS_SZ; i++) begin
                    m_j = (m_ptr[c] + i) % RS_SZ;
                    if (rs_valid[m_j] && rs_ready[m_j] && !squash && (int'(rs_fu_type[2*m_j +: 2]) == c))
                        mq.push_back(m_j);
                end
                m_lim = (c == 0) ? NUM_ALU : 1;
                if (c == 1 && mult_stall) m_lim = 0;
                if (c == 2 && m_busy)     m_lim = 0;
                if (mq.size() < m_lim)    m_lim = mq.size();
                for (int k = 0; k < m_lim; k++) begin
                    e_iss[mq[k]] = 1'b1;
                    case (c)
                        0: begin e_av[k] = 1'b1; e_aidx[k] = mq[k]; end
                        1: begin e_mv = 1'b1; e_midx = mq[k]; end
                        2: begin e_dv = 1'b1; e_didx = mq[k]; end
                        default: begin e_bv = 1'b1; e_bidx = mq[k]; end
                    endcase
                end
                if (m_lim > 0) m_ptr[c] = (mq[m_lim-1] + 1) % RS_SZ;
                if (c == 2 && m_lim > 0) m_div_free = m_cyc + DIV_LAT;
            end
        end
        check("m_issuing", rs_data_issuing, e_iss);
        check("m_alu_valid", alu_issue_valid, e_av);
        for (int k = 0; k < NUM_ALU; k++)
            if (e_av[k]) check("m_alu_idx", alu_issue_idx[k*IW +: IW], e_aidx[k]);
        check("m_mult_valid", mult_issue_valid, e_mv);
        if (e_mv) check("m_mult_idx", mult_issue_idx, e_midx);
        check("m_div_valid", div_issue_valid, e_dv);
        if (e_dv) check("m_div_idx", div_issue_idx, e_didx);
        check("m_br_valid", br_issue_valid, e_bv);
        if (e_bv) check("m_br_idx", br_issue_idx, e_bidx);
        check("m_div_busy", div_busy, m_busy);
    end

    // ---------------- stimulus with hand-computed anchors ----------------------
    int rst_left;

    initial begin
        clear_in();
        rs_valid = '1;
        rs_ready = '1;
        repeat (2) @(posedge clock);
        #3;
        check("rst_issuing", rs_data_issuing, 0);
        check("rst_alu_valid", alu_issue_valid, 0);
        check("rst_div_busy", div_busy, 0);

        // divider occupancy: entries 2,7 DIV
        @(posedge clock); #1;
        reset = 1'b1;
        clear_in(); set_ent(2, 2'd2); set_ent(7, 2'd2);
        #2;
        check("div_first_valid", div_issue_valid, 1);
        check("div_first_idx", div_issue_idx, 2);
        for (int t = 1; t < DIV_LAT; t++) begin
            @(posedge clock); #3;
            check("div_busy_hold", div_busy, 1);
            check("div_blocked", div_issue_valid, 0);
        end
        @(posedge clock); #3;
        check("div_free_busy", div_busy, 0);
        check("div_second_valid", div_issue_valid, 1);
        check("div_second_idx", div_issue_idx, 7);

        // ALU round robin: 3,5,9
        @(posedge clock); #1;
        clear_in(); set_ent(3, 2'd0); set_ent(5, 2'd0); set_ent(9, 2'd0);
        #2;
        check("alu_rr1_valid", alu_issue_valid, 2'b11);
        check("alu_rr1_idx", alu_issue_idx, {4'd5, 4'd3});
        check("alu_rr1_issuing", rs_data_issuing, 16'h0028);
        @(posedge clock); #3;
        check("alu_rr2_idx", alu_issue_idx, {4'd3, 4'd9});
        check("alu_rr2_issuing", rs_data_issuing, 16'h0208);
        @(posedge clock); #3;
        check("alu_rr3_idx", alu_issue_idx, {4'd9, 4'd5});

        // wrap: walk ALU ptr to 14, then 15,1
        @(posedge clock); #1;
        clear_in(); set_ent(13, 2'd0);
        #2 check("alu_to14_issuing", rs_data_issuing, 16'h2000);
        @(posedge clock); #1;
        clear_in(); set_ent(15, 2'd0); set_ent(1, 2'd0);
        #2;
        check("wrap_idx", alu_issue_idx, {4'd1, 4'd15});
        check("wrap_issuing", rs_data_issuing, 16'h8002);
        @(posedge clock); #1;
        clear_in(); set_ent(1, 2'd0); set_ent(2, 2'd0);
        #2 check("wrap_ptr2_idx", alu_issue_idx, {4'd1, 4'd2});

        // mixed classes, multiplier stalled
        @(posedge clock); #1;
        clear_in();
        repeat (DIV_LAT) @(posedge clock);
        #1;
        set_ent(0, 2'd0); set_ent(1, 2'd1); set_ent(4, 2'd3); set_ent(6, 2'd2);
        mult_stall = 1'b1;
        #2;
        check("mix_issuing", rs_data_issuing, 16'h0051);
        check("mix_mult_valid", mult_issue_valid, 0);
        check("mix_br", {br_issue_valid, br_issue_idx}, {1'b1, 4'd4});
        check("mix_div", {div_issue_valid, div_issue_idx}, {1'b1, 4'd6});
        check("mix_alu", {alu_issue_valid, alu_issue_idx[IW-1:0]}, {2'b01, 4'd0});
        @(posedge clock); #1;
        clear_in(); set_ent(1, 2'd1); set_ent(3, 2'd1);
        #2 check("mult_ptr_held", {mult_issue_valid, mult_issue_idx}, {1'b1, 4'd1});

        // squash with every entry eligible
        @(posedge clock); #1;
        clear_in(); rs_valid = '1; rs_ready = '1; squash = 1'b1;
        #2;
        check("sq_issuing", rs_data_issuing, 0);
        check("sq_alu_valid", alu_issue_valid, 0);
        check("sq_div_busy", div_busy, 1);
        @(posedge clock); #1;
        squash = 1'b0;
        #2 check("sq_ptr_held", alu_issue_idx, {4'd2, 4'd1});

        // reset in the middle of a divide
        @(posedge clock); #1;
        clear_in();
        repeat (DIV_LAT) @(posedge clock);
        #1;
        set_ent(0, 2'd2);
        #2 check("rd_grant", {div_issue_valid, div_issue_idx}, {1'b1, 4'd0});
        @(posedge clock); #1;
        clear_in();
        @(posedge clock);
        @(posedge clock);
        #1 check("rd_busy_before", div_busy, 1);
        #1 reset = 1'b0;
        #1 check("rd_busy_async", div_busy, 0);
        set_ent(2, 2'd0); set_ent(14, 2'd0); set_ent(0, 2'd2); set_ent(9, 2'd2);
        #1 check("rd_issuing_in_rst", rs_data_issuing, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        #2;
        check("rd_alu_idx", alu_issue_idx, {4'd14, 4'd2});
        check("rd_div", {div_issue_valid, div_issue_idx}, {1'b1, 4'd0});
        check("rd_issuing", rs_data_issuing, 16'h4005);

        // randomized traffic
        rst_left = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clock); #1;
            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = 2;
            reset = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            rs_valid   = RS_SZ'($urandom);
            rs_ready   = RS_SZ'($urandom | $urandom);
            rs_fu_type = $urandom;
            squash     = ($urandom_range(0, 15) == 0);
            mult_stall = ($urandom_range(0, 3) == 0);
        end

        @(posedge clock); #1;
        reset = 1'b1;
        clear_in();
        @(posedge clock);
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
